// File: rtl/sys_reg_node_if.sv
// sys_reg_node_if: read-strobe / broadcast-write bus between the dispatcher
// (master) and a system-register leaf node (slave).
interface sys_reg_node_if #(
   parameter int REG_WIDTH = 64
);
   logic                 rd_en;
   logic [2:0]           rd_regnum;
   logic [1:0]           rd_plevel;
   logic                 rd_valid;
   logic [REG_WIDTH-1:0] rd_val;
   logic                 rd_fault;
   logic                 wr_en;
   logic [4:0]           wr_group;
   logic [2:0]           wr_regnum;
   logic [1:0]           wr_plevel;
   logic [REG_WIDTH-1:0] wr_val;
   logic                 wr_ack;
   logic                 wr_fault;
   logic                 timer_irq;

   modport master (
      output rd_en, rd_regnum, rd_plevel,
      output wr_en, wr_group, wr_regnum, wr_plevel, wr_val,
      input  rd_valid, rd_val, rd_fault, wr_ack, wr_fault, timer_irq
   );

   modport slave (
      input  rd_en, rd_regnum, rd_plevel,
      input  wr_en, wr_group, wr_regnum, wr_plevel, wr_val,
      output rd_valid, rd_val, rd_fault, wr_ack, wr_fault, timer_irq
   );
endinterface

// File: rtl/sys_reg_node.sv
// sys_reg_node: leaf of the system-register star bus. Owns one group of
// eight slots: free-running CYCLE counter, two scratch registers, CTRL and
// (optionally) a compare timer with level interrupt. Privilege is checked
// per register; reserved slots answer with a fault.
// Build option: define SYS_REG_NODE_TIMER_EN to implement TIMECMP,
// STATUS.pend, CTRL.ie and timer_irq; otherwise slots 3/4 are reserved.
module sys_reg_node #(
   parameter int REG_WIDTH = 64,
   parameter int GROUP_ID  = 10
) (
   input logic           clk,
   input logic           rst,
   sys_reg_node_if.slave bus
);
   localparam logic [4:0] GRP = 5'(GROUP_ID);

   logic [REG_WIDTH-1:0] cycle_q, scratch0_q, scratch1_q;
   logic                 cen_q;
`ifdef SYS_REG_NODE_TIMER_EN
   localparam logic [REG_WIDTH-1:0] ONES = '1;
   logic [REG_WIDTH-1:0] timecmp_q;
   logic                 pend_q, ie_q, pend_set;
   logic                 we_timecmp, we_status;
`endif

   logic                 wr_hit, wr_ok, wr_acc, rd_ok;
   logic                 we_cycle, we_s0, we_s1, we_ctrl;
   logic [REG_WIDTH-1:0] rd_data;

   logic                 rd_valid_q, rd_fault_q, wr_ack_q, wr_fault_q;
   logic [REG_WIDTH-1:0] rd_val_q;

   // Minimum privilege per slot; reserved slots never pass.
   function automatic logic priv_ok(input logic [2:0] regnum,
                                    input logic [1:0] pl,
                                    input logic       is_wr);
      logic ok;
      ok = 1'b0;
      case (regnum)
         3'd0:       ok = is_wr ? (pl == 2'd3) : 1'b1;
         3'd1, 3'd2: ok = (pl >= 2'd1);
         3'd5:       ok = (pl == 2'd3);
`ifdef SYS_REG_NODE_TIMER_EN
         3'd3:       ok = (pl == 2'd3);
         3'd4:       ok = (pl >= 2'd2);
`endif
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign wr_hit   = bus.wr_en && (bus.wr_group == GRP);
   assign wr_ok    = priv_ok(bus.wr_regnum, bus.wr_plevel, 1'b1);
   assign rd_ok    = priv_ok(bus.rd_regnum, bus.rd_plevel, 1'b0);
   assign wr_acc   = wr_hit && wr_ok;
   assign we_cycle = wr_acc && (bus.wr_regnum == 3'd0);
   assign we_s0    = wr_acc && (bus.wr_regnum == 3'd1);
   assign we_s1    = wr_acc && (bus.wr_regnum == 3'd2);
   assign we_ctrl  = wr_acc && (bus.wr_regnum == 3'd5);

   // Read mux over current (pre-edge) register state.
   always_comb begin
      rd_data = '0;
      case (bus.rd_regnum)
         3'd0: rd_data = cycle_q;
         3'd1: rd_data = scratch0_q;
         3'd2: rd_data = scratch1_q;
         3'd5: begin
            rd_data[0] = cen_q;
`ifdef SYS_REG_NODE_TIMER_EN
            rd_data[1] = ie_q;
`endif
         end
`ifdef SYS_REG_NODE_TIMER_EN
         3'd3: rd_data = timecmp_q;
         3'd4: rd_data[0] = pend_q;
`endif
         default: rd_data = '0;
      endcase
   end

   // Cycle counter: a write overrides that cycle's increment; wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           cycle_q <= '0;
      else if (we_cycle) cycle_q <= bus.wr_val;
      else if (cen_q)    cycle_q <= cycle_q + REG_WIDTH'(1);
   end

   // Scratch registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scratch0_q <= '0;
         scratch1_q <= '0;
      end else begin
         if (we_s0) scratch0_q <= bus.wr_val;
         if (we_s1) scratch1_q <= bus.wr_val;
      end
   end

   // CTRL: only cen (and ie when the timer exists) are stored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          cen_q <= 1'b1;
      else if (we_ctrl) cen_q <= bus.wr_val[0];
   end

`ifdef SYS_REG_NODE_TIMER_EN
   assign we_timecmp = wr_acc && (bus.wr_regnum == 3'd3);
   assign we_status  = wr_acc && (bus.wr_regnum == 3'd4);
   assign pend_set   = cen_q && (cycle_q >= timecmp_q);

   // Timer state: compare value, interrupt enable, pend (set beats W1C).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timecmp_q <= ONES;
         ie_q      <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         if (we_timecmp) timecmp_q <= bus.wr_val;
         if (we_ctrl)    ie_q      <= bus.wr_val[1];
         if (pend_set)                          pend_q <= 1'b1;
         else if (we_status && bus.wr_val[0])   pend_q <= 1'b0;
      end
   end

   assign bus.timer_irq = pend_q & ie_q;
`else
   assign bus.timer_irq = 1'b0;
`endif

   // One-cycle registered responses; data forced to 0 on fault or idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_val_q   <= '0;
         rd_fault_q <= 1'b0;
         wr_ack_q   <= 1'b0;
         wr_fault_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         rd_val_q   <= (bus.rd_en && rd_ok) ? rd_data : '0;
         rd_fault_q <= bus.rd_en && !rd_ok;
         wr_ack_q   <= wr_hit;
         wr_fault_q <= wr_hit && !wr_ok;
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_val   = rd_val_q;
   assign bus.rd_fault = rd_fault_q;
   assign bus.wr_ack   = wr_ack_q;
   assign bus.wr_fault = wr_fault_q;
endmodule

// File: tb/tb_sys_reg_node.sv
// tb_sys_reg_node: directed table of bus vectors plus hand sequences for the
// counter, timer and asynchronous reset corner cases.
module tb_sys_reg_node;
`ifdef SYS_REG_NODE_TIMER_EN
   localparam bit TMR = 1'b1;
`else
   localparam bit TMR = 1'b0;
`endif
   localparam logic [63:0] ONES = '1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   sys_reg_node_if #(.REG_WIDTH(64)) bus ();

   sys_reg_node #(.REG_WIDTH(64), .GROUP_ID(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [4:0]  grp;
      logic [2:0]  wreg;
      logic [1:0]  wpl;
      logic [63:0] wv;
      bit          re;
      logic [2:0]  rreg;
      logic [1:0]  rpl;
      logic        e_rv;
      logic [63:0] e_val;
      logic        e_rf;
      logic        e_ack;
      logic        e_wf;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(input bit we, input logic [4:0] grp,
                               input logic [2:0] wreg, input logic [1:0] wpl,
                               input logic [63:0] wv, input bit re,
                               input logic [2:0] rreg, input logic [1:0] rpl,
                               input logic e_rv, input logic [63:0] e_val,
                               input logic e_rf, input logic e_ack,
                               input logic e_wf);
      vec_t v;
      v.we = we; v.grp = grp; v.wreg = wreg; v.wpl = wpl; v.wv = wv;
      v.re = re; v.rreg = rreg; v.rpl = rpl;
      v.e_rv = e_rv; v.e_val = e_val; v.e_rf = e_rf;
      v.e_ack = e_ack; v.e_wf = e_wf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of bus inputs, then sample #1 after the capturing edge.
   task automatic op(input bit we, input logic [4:0] grp,
                     input logic [2:0] wreg, input logic [1:0] wpl,
                     input logic [63:0] wv, input bit re,
                     input logic [2:0] rreg, input logic [1:0] rpl);
      @(negedge clk);
      bus.wr_en = we; bus.wr_group = grp; bus.wr_regnum = wreg;
      bus.wr_plevel = wpl; bus.wr_val = wv;
      bus.rd_en = re; bus.rd_regnum = rreg; bus.rd_plevel = rpl;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] r, input logic [1:0] pl,
                     input logic [63:0] v);
      op(1'b1, 5'd10, r, pl, v, 1'b0, 3'd0, 2'd0);
   endtask

   task automatic rd(input logic [2:0] r, input logic [1:0] pl);
      op(1'b0, 5'd10, 3'd0, 2'd0, 64'd0, 1'b1, r, pl);
   endtask

   task automatic idle();
      op(1'b0, 5'd10, 3'd0, 2'd0, 64'd0, 1'b0, 3'd0, 2'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".rd_valid"}, 64'(bus.rd_valid), 64'd0);
      chk({tag, ".rd_val"},   bus.rd_val,        64'd0);
      chk({tag, ".rd_fault"}, 64'(bus.rd_fault), 64'd0);
      chk({tag, ".wr_ack"},   64'(bus.wr_ack),   64'd0);
      chk({tag, ".wr_fault"}, 64'(bus.wr_fault), 64'd0);
      chk({tag, ".irq"},      64'(bus.timer_irq), 64'd0);
   endtask

   initial begin
      logic [63:0] a, b;

      bus.rd_en = 1'b0; bus.rd_regnum = '0; bus.rd_plevel = '0;
      bus.wr_en = 1'b0; bus.wr_group = '0; bus.wr_regnum = '0;
      bus.wr_plevel = '0; bus.wr_val = '0;

      //            we grp  wreg wpl wv             re rreg rpl  rv val             rf ack wf
      tbl[0]  = mk(1, 10, 1, 1, 64'hDEAD_BEEF,  0, 0, 0,   0, 64'd0,          0, 1, 0);
      tbl[1]  = mk(0, 10, 0, 0, 64'd0,          1, 1, 1,   1, 64'hDEAD_BEEF,  0, 0, 0);
      tbl[2]  = mk(0, 10, 0, 0, 64'd0,          1, 1, 0,   1, 64'd0,          1, 0, 0);
      tbl[3]  = mk(1,  3, 2, 3, 64'h1234,       0, 0, 0,   0, 64'd0,          0, 0, 0);
      tbl[4]  = mk(0, 10, 0, 0, 64'd0,          1, 2, 3,   1, 64'd0,          0, 0, 0);
      tbl[5]  = mk(0, 10, 0, 0, 64'd0,          1, 6, 3,   1, 64'd0,          1, 0, 0);
      tbl[6]  = mk(1, 10, 7, 3, 64'hFF,         0, 0, 0,   0, 64'd0,          0, 1, 1);
      tbl[7]  = mk(1, 10, 2, 0, 64'h55,         1, 2, 2,   1, 64'd0,          0, 1, 1);
      tbl[8]  = mk(1, 10, 2, 2, 64'hA5A5,       1, 2, 2,   1, 64'd0,          0, 1, 0);
      tbl[9]  = mk(0, 10, 0, 0, 64'd0,          1, 2, 1,   1, 64'hA5A5,       0, 0, 0);
      tbl[10] = mk(0, 10, 0, 0, 64'd0,          1, 5, 3,   1, 64'd1,          0, 0, 0);
      tbl[11] = mk(0, 10, 0, 0, 64'd0,          1, 5, 2,   1, 64'd0,          1, 0, 0);
      tbl[12] = mk(1, 10, 5, 2, 64'd0,          0, 0, 0,   0, 64'd0,          0, 1, 1);
      tbl[13] = mk(0, 10, 0, 0, 64'd0,          1, 5, 3,   1, 64'd1,          0, 0, 0);
      tbl[14] = mk(1, 10, 5, 3, 64'h7,          0, 0, 0,   0, 64'd0,          0, 1, 0);
      tbl[15] = mk(0, 10, 0, 0, 64'd0,          1, 5, 3,   1, TMR ? 64'd3 : 64'd1, 0, 0, 0);
      tbl[16] = mk(0, 10, 0, 0, 64'd0,          1, 3, 3,   1, TMR ? ONES : 64'd0, !TMR, 0, 0);
      tbl[17] = mk(0, 10, 0, 0, 64'd0,          1, 4, 2,   1, 64'd0,          !TMR, 0, 0);
      tbl[18] = mk(1, 10, 3, 2, ONES,           0, 0, 0,   0, 64'd0,          0, 1, 1);
      tbl[19] = mk(0, 10, 0, 0, 64'd0,          1, 4, 1,   1, 64'd0,          1, 0, 0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // CYCLE counts from 0 after reset; consecutive reads differ by one
      rd(3'd0, 2'd0);
      a = bus.rd_val;
      chk("cyc_first.valid", 64'(bus.rd_valid), 64'd1);
      chk("cyc_first.val",   a, 64'd1);
      chk("cyc_first.fault", 64'(bus.rd_fault), 64'd0);
      rd(3'd0, 2'd0);
      b = bus.rd_val;
      chk("cyc_diff", b - a, 64'd1);

      // Table vectors
      for (int i = 0; i < 20; i++) begin
         op(tbl[i].we, tbl[i].grp, tbl[i].wreg, tbl[i].wpl, tbl[i].wv,
            tbl[i].re, tbl[i].rreg, tbl[i].rpl);
         chk($sformatf("v%0d.rd_valid", i), 64'(bus.rd_valid), 64'(tbl[i].e_rv));
         chk($sformatf("v%0d.rd_val", i),   bus.rd_val,        tbl[i].e_val);
         chk($sformatf("v%0d.rd_fault", i), 64'(bus.rd_fault), 64'(tbl[i].e_rf));
         chk($sformatf("v%0d.wr_ack", i),   64'(bus.wr_ack),   64'(tbl[i].e_ack));
         chk($sformatf("v%0d.wr_fault", i), 64'(bus.wr_fault), 64'(tbl[i].e_wf));
         chk($sformatf("v%0d.irq", i),      64'(bus.timer_irq), 64'd0);
      end
      idle();
      chk("idle.rd_valid", 64'(bus.rd_valid), 64'd0);
      chk("idle.wr_ack",   64'(bus.wr_ack),   64'd0);

      // CYCLE write privilege, write override, counter stop, wrap
      wr(3'd0, 2'd2, 64'd5);
      chk("cyc_wr_pl2.fault", 64'(bus.wr_fault), 64'd1);
      wr(3'd0, 2'd3, 64'd100);
      chk("cyc_wr.fault", 64'(bus.wr_fault), 64'd0);
      rd(3'd0, 2'd0);
      chk("cyc_after_wr", bus.rd_val, 64'd100);
      rd(3'd0, 2'd0);
      chk("cyc_after_wr_inc", bus.rd_val, 64'd101);
      wr(3'd0, 2'd3, 64'd100);
      wr(3'd5, 2'd3, 64'd0);
      rd(3'd0, 2'd0);
      chk("cyc_stop_a", bus.rd_val, 64'd101);
      rd(3'd0, 2'd0);
      chk("cyc_stop_b", bus.rd_val, 64'd101);
      wr(3'd5, 2'd3, 64'd1);
      wr(3'd0, 2'd3, ONES);
      rd(3'd0, 2'd0);
      chk("cyc_wrap_max", bus.rd_val, ONES);
      rd(3'd0, 2'd0);
      chk("cyc_wrap_zero", bus.rd_val, 64'd0);

`ifdef SYS_REG_NODE_TIMER_EN
      // Compare timer: irq rises six edges after CYCLE is set to TIMECMP-5
      wr(3'd3, 2'd3, 64'd1005);
      wr(3'd4, 2'd2, 64'd1);
      wr(3'd5, 2'd3, 64'd3);
      chk("tmr_pre.irq", 64'(bus.timer_irq), 64'd0);
      wr(3'd0, 2'd3, 64'd1000);
      for (int i = 1; i <= 5; i++) begin
         idle();
         chk($sformatf("tmr_wait%0d.irq", i), 64'(bus.timer_irq), 64'd0);
      end
      idle();
      chk("tmr_rise.irq", 64'(bus.timer_irq), 64'd1);
      wr(3'd4, 2'd2, 64'd1);
      chk("tmr_w1c_lose.irq", 64'(bus.timer_irq), 64'd1);
      rd(3'd4, 2'd2);
      chk("tmr_status_pend", bus.rd_val, 64'd1);
      wr(3'd3, 2'd3, ONES);
      wr(3'd4, 2'd2, 64'd1);
      chk("tmr_clear.irq", 64'(bus.timer_irq), 64'd0);
      rd(3'd4, 2'd2);
      chk("tmr_status_clr", bus.rd_val, 64'd0);
`else
      // Without the timer, CTRL.ie and slot 3 stay inert
      wr(3'd5, 2'd3, 64'd3);
      rd(3'd5, 2'd3);
      chk("noirq_ctrl", bus.rd_val, 64'd1);
      wr(3'd3, 2'd3, 64'd0);
      chk("noirq_wr3.fault", 64'(bus.wr_fault), 64'd1);
      chk("noirq.irq", 64'(bus.timer_irq), 64'd0);
`endif

      // Asynchronous reset while a read response is in flight
      wr(3'd1, 2'd1, 64'h77);
      wr(3'd5, 2'd3, 64'd0);
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b1; bus.rd_regnum = 3'd1; bus.rd_plevel = 2'd1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.rd_en = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      @(posedge clk);
      #1;
      chk("rst_hold.rd_valid", 64'(bus.rd_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      rd(3'd5, 2'd3);
      chk("rst_ctrl", bus.rd_val, 64'd1);
      rd(3'd1, 2'd1);
      chk("rst_s0", bus.rd_val, 64'd0);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Safety net in case simulation stalls
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
